// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - tx_state_t : 3-bit transmitter state encoding
//   - calc_cpb   : clock cycles per line bit (integer division)
//   - calc_cnt_w : width of a counter that spans 0..cpb-1 (minimum 1 bit)
// No ports; imported with "import uart_pkg::*;".
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    // Encodings 5..7 are unused; the transmitter treats them as a fault and
    // returns to TX_IDLE.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic int calc_cpb(input int base_freq, input int baudrate);
        return base_freq / baudrate;
    endfunction

    // $clog2(1) is 0, so a one-cycle bit period still gets a 1-bit counter.
    function automatic int calc_cnt_w(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CPB-1 and wraps; o_tick marks the last cycle
// of each bit period.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  synchronous active-high reset, clears the counter
//   i_restart in  hold the counter at 0 (next cycle starts a fresh bit period)
//   o_tick    out high while the counter holds CPB-1
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CPB   = 434,
    parameter int CNT_W = calc_cnt_w(CPB)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CPB - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tick = (r_count == LAST_COUNT);

    // NOTE: registers are written with non-blocking assignments so every
    // always_ff block samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter (optional parity bit). A frame is start bit, 8 data
// bits LSB first, optional parity, stop bit; each bit lasts CPB clock cycles.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (beats send)
//   parallel_in in 8 byte to send, captured when a request is accepted
//   send        in   request, accepted only in TX_IDLE
//   serial_out  out  UART line, idle high
//   busy        out  high for the whole frame
//   done        out  one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int   BASE_FREQ  = 50_000_000,
    parameter int   BAUDRATE   = 115_200,
    parameter logic PARITY_EN  = 1'b0,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] parallel_in,
    input  logic       send,
    output logic       serial_out,
    output logic       busy,
    output logic       done
);

    localparam int CPB = calc_cpb(BASE_FREQ, BAUDRATE);

    tx_state_t  r_state;
    tx_state_t  w_next_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_parity;
    logic       w_tick;
    logic       w_restart;

    // Holding the counter at 0 while idle makes the start bit begin a full
    // bit period on the cycle after acceptance.
    assign w_restart = (r_state == TX_IDLE);

    uart_baud_tick #(
        .CPB (CPB)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TX_IDLE:   if (send)   w_next_state = TX_START;
            TX_START:  if (w_tick) w_next_state = TX_DATA;
            TX_DATA: begin
                if (w_tick && (r_bit_idx == 3'(DATA_BITS - 1))) begin
                    w_next_state = PARITY_EN ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: if (w_tick) w_next_state = TX_STOP;
            TX_STOP:   if (w_tick) w_next_state = TX_IDLE;
            default:               w_next_state = TX_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        serial_out = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            TX_START: begin
                serial_out = 1'b0;
                busy       = 1'b1;
            end
            TX_DATA: begin
                serial_out = r_shift[0];
                busy       = 1'b1;
            end
            TX_PARITY: begin
                serial_out = r_parity;
                busy       = 1'b1;
            end
            TX_STOP: begin
                serial_out = 1'b1;
                busy       = 1'b1;
                done       = w_tick;
            end
            default: begin
                serial_out = 1'b1;
                busy       = 1'b0;
                done       = 1'b0;
            end
        endcase
    end

    // Datapath: the byte is captured once at acceptance and shifted out LSB
    // first. Parity is computed at capture because shifting destroys the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (send) begin
                        r_shift   <= parallel_in;
                        r_parity  <= (^parallel_in) ^ PARITY_ODD;
                        r_bit_idx <= '0;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 BASE_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 BAUDRATE, default 115_200, line bit rate in bit/s.
REQ-003 PARITY_EN, default 0, 1 inserts a parity bit between data and stop.
REQ-004 PARITY_ODD, default 0, parity sense when PARITY_EN=1: 0 even, 1 odd.
REQ-005 clk  input  1  single clock, all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 parallel_in  input  8  byte to transmit, captured on accepted send.
REQ-008 send  input  1  transmit request, level-sampled every cycle.
REQ-009 serial_out  output  1  UART line, idle high.
REQ-010 busy  output  1  high from the cycle after acceptance until frame end.
REQ-011 done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 Bit period CPB = BASE_FREQ / BAUDRATE clock cycles, integer division (434 at defaults); every line bit SHALL last exactly CPB cycles.
REQ-013 States: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP; any unused encoding SHALL go to TX_IDLE next cycle with serial_out=1.
REQ-014 TX_IDLE: serial_out=1, busy=0; send=1 sampled at edge N latches parallel_in into a shift register and enters TX_START.
REQ-015 TX_START: serial_out=0 for cycles N+1..N+CPB, busy=1.
REQ-016 TX_DATA: 8 bits LSB first, bit k driven for cycles N+1+(k+1)*CPB .. N+(k+2)*CPB; 3-bit index counts 0..7.
REQ-017 TX_PARITY (only if PARITY_EN=1): serial_out = XOR of the 8 latched bits XOR PARITY_ODD, for one CPB.
REQ-018 TX_STOP: serial_out=1 for CPB cycles; done=1 on its final cycle; then TX_IDLE.
REQ-019 Frame length: 10*CPB cycles (11*CPB with parity), from N+1 until busy falls.
REQ-020 send while busy=1 SHALL be ignored; parallel_in changes after acceptance SHALL NOT alter the frame.
REQ-021 Back-to-back: send held high SHALL be accepted in the first TX_IDLE cycle after done, giving exactly one idle-high cycle between frames.
REQ-022 Bit-cycle counter SHALL be width ceil(log2(CPB)) minimum 1, count 0..CPB-1, wrap to 0 on each bit boundary.

Reset
REQ-023 rst=1 at an edge SHALL, regardless of state (mid-frame included), force TX_IDLE, serial_out=1, busy=0, done=0, counters and shift register to 0 from the next cycle.
REQ-024 rst has priority over send in the same cycle; the request is dropped.

Structure
REQ-025 State encodings (3-bit) and a CPB-calculation constant function SHALL live in shared package uart_pkg, also used by uart_rx.
REQ-026 Optional sub-module uart_baud_tick (CPB counter, restart input, tick output) SHALL be the only sub-module.

Verification (BASE_FREQ=1_000_000, BAUDRATE=100_000, CPB=10)
REQ-027 send=1 one cycle with parallel_in=0xA5, PARITY_EN=0 -> line 0,1,0,1,0,0,1,0,1,1, each 10 cycles; busy high 100 cycles; done once at cycle 100.
REQ-028 PARITY_EN=1, PARITY_ODD=0, 0xA5 -> parity bit 0; PARITY_ODD=1 -> parity bit 1; frame 110 cycles.
REQ-029 send pulsed with 0x3C at cycle 30 of a 0xFF frame -> 0xFF frame unchanged, 0x3C never sent.
REQ-030 send held high, parallel_in=0x00 then 0xFF -> two frames, exactly 1 idle-high cycle between stop and next start.
REQ-031 rst=1 at cycle 45 of a frame -> serial_out=1, busy=0 next cycle; later send of 0x55 -> clean full frame.
REQ-032 rst and send both high in one cycle -> no start bit, line stays high.
